// File: rtl/alu4_pkg.sv
// alu4_pkg -- shared constants for the nibble-serial ALU sequencer.
//   NIB_W      : width of one alu4 pass (4 bits)
//   OP_*       : request opcode encoding seen on in_op
//   ALU_*      : operation select driven onto the alu4 op port
//   state_e    : sequencer FSM state encoding
// Helpers classify opcodes into arithmetic and shift groups.
package alu4_pkg;

   localparam int NIB_W = 4;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_LSR = 3'd6;
   localparam logic [2:0] OP_ASR = 3'd7;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_AND = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
   endfunction

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_LSR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/alu4.sv
// alu4 -- combinational WIDTH-bit ALU slice.
//   a_i, b_i  : operands
//   b_inv_i   : invert b before the adder (subtract)
//   y_i       : carry-in to the adder
//   op_i      : 0 ADD, 1 AND, 2 OR, 3 XOR
//   s_o       : result
//   c_o, v_o  : adder carry-out and signed overflow (0 for logic ops)
module alu4 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             b_inv_i,
   input  logic             y_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o,
   output logic             v_o
);
   import alu4_pkg::*;

   logic [WIDTH-1:0] bb_s;
   logic [WIDTH:0]   sum_s;

   // Operand conditioning, adder and result select.
   always_comb begin
      bb_s  = b_inv_i ? ~b_i : b_i;
      sum_s = {1'b0, a_i} + {1'b0, bb_s} + {{WIDTH{1'b0}}, y_i};
      s_o   = '0;
      c_o   = 1'b0;
      v_o   = 1'b0;
      case (op_i)
         ALU_ADD: begin
            s_o = sum_s[WIDTH-1:0];
            c_o = sum_s[WIDTH];
            // overflow: like-signed inputs give an opposite-signed sum
            v_o = (a_i[WIDTH-1] == bb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
         end
         ALU_AND: s_o = a_i & b_i;
         ALU_OR:  s_o = a_i | b_i;
         ALU_XOR: s_o = a_i ^ b_i;
         default: s_o = '0;
      endcase
   end

endmodule

// File: rtl/alu4_seq.sv
// alu4_seq -- multi-cycle ALU that runs one shared 4-bit alu4 slice over
// NIBBLES passes (W = 4*NIBBLES bits).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (accepted only in IDLE)
//   in_op, in_a, in_b   : opcode and operands, in_cin carry-in for ADC
//   res_valid/res_ready : result handshake, result held until retired
//   res_s, res_c, res_v, res_z : result, carry, signed overflow, zero
//   busy                : operation in progress or result pending
// Optional feature: define ALU4_SEQ_SHIFT_EN to build the LSR/ASR
// datapath; otherwise ops 6/7 return in_a unchanged with c = v = 0.
module alu4_seq
   import alu4_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [NIB_W*NIBBLES-1:0]   in_a,
   input  logic [NIB_W*NIBBLES-1:0]   in_b,
   input  logic                       in_cin,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [NIB_W*NIBBLES-1:0]   res_s,
   output logic                       res_c,
   output logic                       res_v,
   output logic                       res_z,
   output logic                       busy
);

   localparam int         W      = NIB_W * NIBBLES;
   localparam logic [3:0] K_LAST = 4'(NIBBLES - 1);

   state_e           state_q;
   logic [3:0]       k_q;
   logic [2:0]       op_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             carry_q;
   logic [W-1:0]     work_q;
   logic             zacc_q;
   logic             res_valid_q;
   logic [W-1:0]     res_s_q;
   logic             res_c_q;
   logic             res_v_q;
   logic             res_z_q;

   logic [3:0]       idx_s;
   logic [NIB_W-1:0] alu_a_s;
   logic [NIB_W-1:0] alu_b_s;
   logic             alu_b_inv_s;
   logic             alu_y_s;
   logic [1:0]       alu_op_s;
   logic [NIB_W-1:0] alu_s_s;
   logic             alu_c_s;
   logic             alu_v_s;
   logic [W-1:0]     work_d;
   logic             last_s;
   logic             nib_zero_s;
   logic             shift_c_s;
`ifdef ALU4_SEQ_SHIFT_EN
   logic [W:0]       a_ext_s;
`endif

   // Per-pass nibble selection and alu4 control.
   always_comb begin
      if (is_shift(op_q)) begin
         idx_s = K_LAST - k_q;      // shifts walk MSB-first
      end else begin
         idx_s = k_q;
      end
      alu_a_s     = a_q[idx_s*NIB_W +: NIB_W];
      alu_b_s     = b_q[idx_s*NIB_W +: NIB_W];
      alu_b_inv_s = 1'b0;
      alu_y_s     = 1'b0;
      alu_op_s    = ALU_ADD;
`ifdef ALU4_SEQ_SHIFT_EN
      // Bit above the MSB is the shift-in: sign for ASR, zero for LSR.
      a_ext_s   = {(op_q == OP_ASR) ? a_q[W-1] : 1'b0, a_q};
      shift_c_s = a_q[0];
`else
      shift_c_s = 1'b0;
`endif
      case (op_q)
         OP_ADD, OP_ADC: alu_y_s = carry_q;
         OP_SUB: begin
            alu_b_inv_s = 1'b1;
            alu_y_s     = carry_q;
         end
         OP_AND: alu_op_s = ALU_AND;
         OP_OR:  alu_op_s = ALU_OR;
         OP_XOR: alu_op_s = ALU_XOR;
         OP_LSR, OP_ASR: begin
            // Shift result is formed at the adder input and passed
            // through as a + 0 + 0.
            alu_b_s = '0;
`ifdef ALU4_SEQ_SHIFT_EN
            alu_a_s = a_ext_s[idx_s*NIB_W + 1 +: NIB_W];
`else
            alu_a_s = a_q[idx_s*NIB_W +: NIB_W];
`endif
         end
         default: alu_op_s = ALU_ADD;
      endcase
   end

   alu4 #(
      .WIDTH (NIB_W)
   ) u_alu4 (
      .a_i     (alu_a_s),
      .b_i     (alu_b_s),
      .b_inv_i (alu_b_inv_s),
      .y_i     (alu_y_s),
      .op_i    (alu_op_s),
      .s_o     (alu_s_s),
      .c_o     (alu_c_s),
      .v_o     (alu_v_s)
   );

   // Merge the current pass into the working result.
   always_comb begin
      work_d                        = work_q;
      work_d[idx_s*NIB_W +: NIB_W]  = alu_s_s;
      last_s                        = (k_q == K_LAST);
      nib_zero_s                    = (alu_s_s == 4'h0);
   end

   // Sequencer FSM with registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= 4'd0;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         work_q      <= '0;
         zacc_q      <= 1'b1;
         res_valid_q <= 1'b0;
         res_s_q     <= '0;
         res_c_q     <= 1'b0;
         res_v_q     <= 1'b0;
         res_z_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_q    <= in_op;
                  a_q     <= in_a;
                  b_q     <= in_b;
                  k_q     <= 4'd0;
                  work_q  <= '0;
                  zacc_q  <= 1'b1;
                  // nibble-0 carry-in: SUB adds 1 to complete ~b
                  case (in_op)
                     OP_ADC:  carry_q <= in_cin;
                     OP_SUB:  carry_q <= 1'b1;
                     default: carry_q <= 1'b0;
                  endcase
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               work_q  <= work_d;
               zacc_q  <= zacc_q & nib_zero_s;
               carry_q <= alu_c_s;
               if (last_s) begin
                  k_q         <= 4'd0;
                  res_s_q     <= work_d;
                  res_z_q     <= zacc_q & nib_zero_s;
                  res_valid_q <= 1'b1;
                  if (is_arith(op_q)) begin
                     res_c_q <= alu_c_s;
                     res_v_q <= alu_v_s;
                  end else if (is_shift(op_q)) begin
                     res_c_q <= shift_c_s;
                     res_v_q <= 1'b0;
                  end else begin
                     res_c_q <= 1'b0;
                     res_v_q <= 1'b0;
                  end
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q + 4'd1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign res_valid = res_valid_q;
   assign res_s     = res_s_q;
   assign res_c     = res_c_q;
   assign res_v     = res_v_q;
   assign res_z     = res_z_q;

endmodule

// File: tb/tb_alu4_seq.sv
// Scoreboard bench for alu4_seq (NIBBLES = 4, W = 16). Build with
// +define+ALU4_SEQ_SHIFT_EN to select the shift expectations.
module tb_alu4_seq;

   localparam int NIBBLES = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [15:0] in_a = 16'h0000;
   logic [15:0] in_b = 16'h0000;
   logic        in_cin = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [15:0] res_s;
   logic        res_c;
   logic        res_v;
   logic        res_z;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic rv_prev = 1'b0;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
      logic        z;
      int          acc;
      string       name;
   } exp_t;

   exp_t sb[$];

   alu4_seq #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_s     (res_s),
      .res_c     (res_c),
      .res_v     (res_v),
      .res_z     (res_z),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: latency on result rise, full compare on retirement.
   always @(negedge clk) begin
      exp_t e;
      if (res_valid === 1'b1 && rv_prev !== 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: res_valid rose with nothing outstanding (cycle %0d)", cyc);
         end else begin
            chk({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc), 32'(NIBBLES));
         end
      end
      if (res_valid === 1'b1 && res_ready === 1'b1 && sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.name, "_s"}, 32'(res_s), 32'(e.s));
         chk({e.name, "_c"}, 32'(res_c), 32'(e.c));
         chk({e.name, "_v"}, 32'(res_v), 32'(e.v));
         chk({e.name, "_z"}, 32'(res_z), 32'(e.z));
      end
      rv_prev = res_valid;
   end

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic ev, input logic ez, input string nm);
      exp_t e;
      wait_ready();
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin;
      @(posedge clk); #1;
      // scramble inputs after acceptance; latched operands must not move
      in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
      e.s = es; e.c = ec; e.v = ev; e.z = ez; e.acc = cyc; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input logic ev, input logic ez, input string nm);
      issue(op, a, b, cin, es, ec, ev, ez, nm);
      drain();
   endtask

   initial begin
      bit ok;
      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_s", 32'(res_s), 32'd0);
      chk("rst_flags", 32'({res_c, res_v, res_z}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed vectors: op, a, b, cin, expected s, c, v, z
      run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "add_carry_nib");
      run_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
      run_op(3'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, "sub_borrow");
      run_op(3'd2, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, "sub_noborrow");
      run_op(3'd5, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "xor_zero");
      run_op(3'd1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "adc_wrap");
      run_op(3'd3, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, "and");
      run_op(3'd4, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, "or");
      run_op(3'd0, 16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ignores_cin");
`ifdef ALU4_SEQ_SHIFT_EN
      run_op(3'd7, 16'h8003, 16'h0000, 1'b0, 16'hC001, 1'b1, 1'b0, 1'b0, "asr");
      run_op(3'd6, 16'h8003, 16'h0000, 1'b0, 16'h4001, 1'b1, 1'b0, 1'b0, "lsr");
      run_op(3'd6, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "lsr_zero");
`else
      run_op(3'd7, 16'h8003, 16'h0000, 1'b0, 16'h8003, 1'b0, 1'b0, 1'b0, "asr_off");
      run_op(3'd6, 16'h8003, 16'h0000, 1'b0, 16'h8003, 1'b0, 1'b0, 1'b0, "lsr_off");
      run_op(3'd6, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "lsr_off_zero");
`endif

      // back-pressure: result held, second request ignored
      res_ready = 1'b0;
      issue(3'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, "hold_add");
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("hold_wait_valid_timeout", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 3'd5; in_a = 16'hFFFF; in_b = 16'h0F0F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_res_s", 32'(res_s), 32'h2345);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;          // in_valid still high across retirement
      @(posedge clk); #1;        // retirement edge
      in_valid = 1'b0;
      @(negedge clk);
      chk("retire_in_ready", 32'(in_ready), 32'd1);
      chk("retire_busy", 32'(busy), 32'd0);
      chk("retire_sb_empty", 32'(sb.size()), 32'd0);
      repeat (6) @(negedge clk);
      chk("ignored_req_idle", 32'(in_ready), 32'd1);

      // reset during the second RUN cycle aborts the request
      wait_ready();
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 3'd0; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
      @(posedge clk); #1;        // accept
      in_valid = 1'b0;
      @(posedge clk); #1;        // now in second RUN cycle
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_res_s", 32'(res_s), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 32'(res_valid), 32'd0);
      end
      run_op(3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "add_after_abort");

      repeat (3) @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/alu4_seq.md
ALU4_SEQ -- requirements
Module: alu4_seq

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit passes per operation; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 in_op  input  3  operation: 0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LSR, 7 ASR.
REQ-007 in_a, in_b  input  W each  operands.
REQ-008 in_cin  input  1  carry-in, used by ADC only.
REQ-009 res_valid  output  1  result held and valid.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_s  output  W  result; res_c, res_v, res_z  output  1 each  carry, signed overflow, zero.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states IDLE, RUN, DONE; in_ready = (state == IDLE).
REQ-014 IDLE: in_valid high -> latch in_op, in_a, in_b, in_cin; clear nibble index k; go to RUN.
REQ-015 RUN: one alu4 pass per cycle; ADD/ADC/SUB/logic ops process nibbles LSB-first (k = 0..NIBBLES-1); shifts process MSB-first.
REQ-016 Nibble carry chain: carry-in to nibble 0 = 0 (ADD), in_cin (ADC), 1 (SUB with b_inv=1); each later nibble takes the previous nibble's alu4 carry-out.
REQ-017 LSR/ASR: shift right by one bit; top nibble receives 0 (LSR) or in_a[W-1] (ASR); each lower nibble receives bit 0 of the nibble above; res_c = in_a[0].
REQ-018 After the last pass go to DONE; res_valid asserted exactly NIBBLES cycles after the accepting edge.
REQ-019 res_c, res_v taken from the final arithmetic pass (top nibble); res_c = 0 and res_v = 0 for AND/OR/XOR; res_v = 0 for shifts; SUB carry convention: res_c = 1 means no borrow.
REQ-020 res_z = 1 iff all W bits of res_s are 0 (accumulated across passes, not from last nibble alone).
REQ-021 DONE: outputs held stable while res_ready low; res_ready high -> IDLE next edge; no request accepted in the same cycle as result retirement.
REQ-022 in_valid ignored outside IDLE; latched operands unaffected by input changes during RUN.

Reset
REQ-023 rst high at any edge -> state IDLE, k = 0, res_valid = 0, busy = 0, res_s = 0, res_c = res_v = res_z = 0; in_ready = 1 the cycle after.
REQ-024 rst asserted during RUN or DONE aborts the operation; no res_valid pulse for the aborted request.

Configuration
REQ-025 Macro ALU4_SEQ_SHIFT_EN: defined -> ops 6/7 execute per REQ-017.
REQ-026 Without ALU4_SEQ_SHIFT_EN: ops 6/7 accepted, complete in NIBBLES cycles with res_s = in_a, res_c = res_v = 0, res_z per REQ-020; no shift datapath synthesized.

Structure
REQ-027 Package alu4_pkg holds the op encoding constants, FSM state encoding, and nibble width constant 4.
REQ-028 Exactly one instance of the team's existing combinational alu4 module (WIDTH=4) performs every pass; sequencer supplies a, b, b_inv, y, op[1:0] per nibble.

Verification
REQ-029 ADD 0x00FF + 0x0001 -> res_s 0x0100, c=0, v=0, z=0, res_valid 4 cycles after accept.
REQ-030 ADD 0x7FFF + 0x0001 -> 0x8000, v=1, c=0; SUB 0x0000 - 0x0001 -> 0xFFFF, c=0, v=0.
REQ-031 XOR 0xA5A5 ^ 0xA5A5 -> 0x0000, z=1, c=0; ADC 0xFFFF + 0x0000 with cin=1 -> 0x0000, c=1, z=1.
REQ-032 With ALU4_SEQ_SHIFT_EN: ASR 0x8003 -> 0xC001, c=1; LSR 0x8003 -> 0x4001, c=1; without macro: same ops -> 0x8003, c=0.
REQ-033 res_ready held low 5 cycles -> result stable, in_ready low, second in_valid ignored; res_ready high -> in_ready high next cycle.
REQ-034 rst pulsed on 2nd RUN cycle -> IDLE next edge, res_valid never asserted, following ADD 0x0001+0x0001 returns 0x0002.
